// File: rtl/write_back_scoreboard.sv
// In-order write-back scoreboard: holds pending GPR writes until their
// ALU / memory / aux (HI/LO/CP0) result arrives, retires them in program
// order to the register-file write port, and answers RAW hazard and
// forwarding queries for the decode stage's rs/rt operands.
// Build option: WB_SCOREBOARD_FORWARD_EN enables result forwarding; when it
// is undefined the fwd outputs are tied to 0 and any match reports busy.

package wb_pkg;
    typedef enum logic [1:0] {
        SRC_NOP = 2'd0,
        SRC_ALU = 2'd1,
        SRC_MEM = 2'd2
    } wr_src_t;

    typedef struct packed {
        logic        valid;
        wr_src_t     src;
        logic [4:0]  dst;
        logic [31:0] value;
    } write_reg_t;
endpackage

module write_back_scoreboard
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int TW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  write_reg_t    issue_wr,
    output logic [TW-1:0] issue_tag,
    input  logic          alu_valid,
    input  logic [TW-1:0] alu_tag,
    input  logic [31:0]   alu_value,
    input  logic          mem_valid,
    input  logic [TW-1:0] mem_tag,
    input  logic [31:0]   mem_value,
    input  logic          aux_valid,
    input  logic [TW-1:0] aux_tag,
    input  logic [31:0]   aux_value,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    output logic          rs_busy,
    output logic          rs_fwd_valid,
    output logic [31:0]   rs_fwd_value,
    output logic          rt_busy,
    output logic          rt_fwd_valid,
    output logic [31:0]   rt_fwd_value,
    output logic [TW:0]   count
);

    logic [4:0]       e_dst [DEPTH];
    wr_src_t          e_src [DEPTH];
    logic [31:0]      e_val [DEPTH];
    logic [DEPTH-1:0] e_done;

    logic [TW-1:0]    head, tail;
    logic [TW:0]      cnt;

    logic [TW-1:0]    off [DEPTH];
    logic [DEPTH-1:0] occ, alu_hit, mem_hit, aux_hit;
    logic             full, alloc, pop;

    // The result value carried by the descriptor is not used here.
    logic unused_value;
    assign unused_value = ^issue_wr.value;

    assign full        = (cnt == (TW+1)'(DEPTH));
    assign issue_ready = !full && !flush;
    assign issue_tag   = tail;
    assign count       = cnt;
    assign alloc       = issue_valid && issue_ready && issue_wr.valid && (issue_wr.dst != 5'd0);
    assign pop         = (cnt != '0) && e_done[head];

    // Per-slot occupancy and result-port hits; a port only completes an
    // occupied, not-yet-done slot whose source matches the port.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            off[i]     = TW'(i) - head;
            occ[i]     = ({1'b0, off[i]} < cnt);
            alu_hit[i] = alu_valid && (alu_tag == TW'(i)) && occ[i] && !e_done[i] && (e_src[i] == SRC_ALU);
            mem_hit[i] = mem_valid && (mem_tag == TW'(i)) && occ[i] && !e_done[i] && (e_src[i] == SRC_MEM);
            aux_hit[i] = aux_valid && (aux_tag == TW'(i)) && occ[i] && !e_done[i] && (e_src[i] == SRC_NOP);
        end
    end

    // Queue state, completions, in-order retire and registered RF write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            e_done   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                e_dst[i] <= 5'd0;
                e_src[i] <= SRC_NOP;
                e_val[i] <= 32'd0;
            end
        end else if (flush) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            e_done <= '0;
            rf_we  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_hit[i]) begin
                    e_val[i]  <= alu_value;
                    e_done[i] <= 1'b1;
                end else if (mem_hit[i]) begin
                    e_val[i]  <= mem_value;
                    e_done[i] <= 1'b1;
                end else if (aux_hit[i]) begin
                    e_val[i]  <= aux_value;
                    e_done[i] <= 1'b1;
                end
            end
            if (alloc) begin
                e_dst[tail]  <= issue_wr.dst;
                e_src[tail]  <= issue_wr.src;
                e_done[tail] <= 1'b0;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                rf_we    <= 1'b1;
                rf_waddr <= e_dst[head];
                rf_wdata <= e_val[head];
                head     <= head + 1'b1;
            end else begin
                rf_we <= 1'b0;
            end
            cnt <= cnt + (TW+1)'(alloc) - (TW+1)'(pop);
        end
    end

    // Oldest-to-youngest scan so the last match seen is the youngest writer.
    function automatic void lookup(input logic [4:0] a, output logic busy,
                                   output logic fv, output logic [31:0] fval);
        logic          hit, hit_done;
        logic [31:0]   hit_val;
        logic [TW-1:0] idx;
        hit      = 1'b0;
        hit_done = 1'b0;
        hit_val  = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + TW'(k);
            if (((TW+1)'(k) < cnt) && (e_dst[idx] == a)) begin
                hit      = 1'b1;
                hit_done = e_done[idx];
                hit_val  = e_val[idx];
            end
        end
        busy = 1'b0;
        fv   = 1'b0;
        fval = 32'd0;
`ifdef WB_SCOREBOARD_FORWARD_EN
        if (a != 5'd0) begin
            if (hit) begin
                if (hit_done) begin
                    fv   = 1'b1;
                    fval = hit_val;
                end else begin
                    busy = 1'b1;
                end
            end else if (rf_we && (rf_waddr == a)) begin
                fv   = 1'b1;
                fval = rf_wdata;
            end
        end
`else
        busy = (a != 5'd0) && (hit || (rf_we && (rf_waddr == a)));
        if (hit_done || (hit_val != 32'd0)) begin
            fval = 32'd0;
        end
`endif
    endfunction

    // rs operand query.
    always_comb begin
        rs_busy      = 1'b0;
        rs_fwd_valid = 1'b0;
        rs_fwd_value = 32'd0;
        lookup(rs_addr, rs_busy, rs_fwd_valid, rs_fwd_value);
    end

    // rt operand query.
    always_comb begin
        rt_busy      = 1'b0;
        rt_fwd_valid = 1'b0;
        rt_fwd_value = 32'd0;
        lookup(rt_addr, rt_busy, rt_fwd_valid, rt_fwd_value);
    end

endmodule

// File: tb/tb_write_back_scoreboard.sv
// Testbench for write_back_scoreboard: directed scenarios with constant
// expectations plus a randomized run checked against a queue-based model.
module tb_write_back_scoreboard;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int TW    = $clog2(DEPTH);
`ifdef WB_SCOREBOARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          flush = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    write_reg_t    issue_wr = '0;
    logic [TW-1:0] issue_tag;
    logic          alu_valid = 1'b0, mem_valid = 1'b0, aux_valid = 1'b0;
    logic [TW-1:0] alu_tag = '0, mem_tag = '0, aux_tag = '0;
    logic [31:0]   alu_value = '0, mem_value = '0, aux_value = '0;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [4:0]    rs_addr = '0, rt_addr = '0;
    logic          rs_busy, rs_fwd_valid, rt_busy, rt_fwd_valid;
    logic [31:0]   rs_fwd_value, rt_fwd_value;
    logic [TW:0]   count;

    int n_vec = 0;
    int n_err = 0;

    write_back_scoreboard #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_wr(issue_wr), .issue_tag(issue_tag),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value),
        .mem_valid(mem_valid), .mem_tag(mem_tag), .mem_value(mem_value),
        .aux_valid(aux_valid), .aux_tag(aux_tag), .aux_value(aux_value),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_busy(rs_busy), .rs_fwd_valid(rs_fwd_valid), .rs_fwd_value(rs_fwd_value),
        .rt_busy(rt_busy), .rt_fwd_valid(rt_fwd_valid), .rt_fwd_value(rt_fwd_value),
        .count(count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: program-order queue ----------------
    typedef struct {
        logic [4:0]  dst;
        wr_src_t     src;
        bit          done;
        logic [31:0] val;
        int          tag;
    } ment_t;

    ment_t       mq[$];
    int          m_tail;
    bit          m_rf_we;
    logic [4:0]  m_rf_waddr;
    logic [31:0] m_rf_wdata;

    function automatic void model_reset();
        mq.delete();
        m_tail     = 0;
        m_rf_we    = 0;
        m_rf_waddr = 0;
        m_rf_wdata = 0;
    endfunction

    function automatic void model_edge();
        bit ready, head_done;
        ready     = (mq.size() < DEPTH) && !flush;
        head_done = (mq.size() > 0) && mq[0].done;
        if (flush) begin
            mq.delete();
            m_tail  = 0;
            m_rf_we = 0;
            return;
        end
        foreach (mq[i]) begin
            if (!mq[i].done) begin
                if (alu_valid && int'(alu_tag) == mq[i].tag && mq[i].src == SRC_ALU) begin
                    mq[i].done = 1; mq[i].val = alu_value;
                end else if (mem_valid && int'(mem_tag) == mq[i].tag && mq[i].src == SRC_MEM) begin
                    mq[i].done = 1; mq[i].val = mem_value;
                end else if (aux_valid && int'(aux_tag) == mq[i].tag && mq[i].src == SRC_NOP) begin
                    mq[i].done = 1; mq[i].val = aux_value;
                end
            end
        end
        if (head_done) begin
            m_rf_we    = 1;
            m_rf_waddr = mq[0].dst;
            m_rf_wdata = mq[0].val;
            void'(mq.pop_front());
        end else begin
            m_rf_we = 0;
        end
        if (issue_valid && ready && issue_wr.valid && issue_wr.dst != 5'd0) begin
            ment_t e;
            e.dst = issue_wr.dst; e.src = issue_wr.src; e.done = 0; e.val = 0; e.tag = m_tail;
            mq.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endfunction

    function automatic void model_query(input logic [4:0] a, output bit busy,
                                        output bit fv, output logic [31:0] fval);
        busy = 0; fv = 0; fval = 0;
        if (a == 0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].dst == a) begin
                if (FWD && mq[i].done) begin fv = 1; fval = mq[i].val; end
                else busy = 1;
                return;
            end
        end
        if (m_rf_we && m_rf_waddr == a) begin
            if (FWD) begin fv = 1; fval = m_rf_wdata; end
            else busy = 1;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 0; flush = 0;
        alu_valid = 0; mem_valid = 0; aux_valid = 0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic do_issue(input wr_src_t s, input logic [4:0] d, input logic v);
        issue_valid = 1;
        issue_wr.valid = v; issue_wr.src = s; issue_wr.dst = d; issue_wr.value = $urandom;
        tick();
        issue_valid = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        rs_addr = 5; rt_addr = 0;
        #1;
        n_vec++; if (count !== 0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_vec++; if (rf_we !== 0) begin n_err++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        n_vec++; if (issue_ready !== 1) begin n_err++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
        n_vec++; if (issue_tag !== 0) begin n_err++; $display("FAIL reset_tag: got %0d want 0", issue_tag); end
        // build up a pending RF write then reset asynchronously mid-cycle
        do_issue(SRC_ALU, 5, 1);
        alu_valid = 1; alu_tag = 0; alu_value = 32'h99;
        tick(); idle();
        tick();
        n_vec++; if (rf_we !== 1) begin n_err++; $display("FAIL pre_areset_we: got %b want 1", rf_we); end
        #1 resetn = 0;
        #1;
        n_vec++; if (rf_we !== 0 || count !== 0) begin n_err++; $display("FAIL areset: got we=%b count=%0d want 0/0", rf_we, count); end
        n_vec++; if (rs_busy !== 0 || rs_fwd_valid !== 0 || rs_fwd_value !== 0) begin
            n_err++; $display("FAIL areset_query: got %b/%b/%h want 0/0/0", rs_busy, rs_fwd_valid, rs_fwd_value); end
        n_vec++; if (rf_waddr !== 0 || rf_wdata !== 0) begin n_err++; $display("FAIL areset_rf: got %0d/%h want 0/0", rf_waddr, rf_wdata); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        rs_addr = 5;
        issue_valid = 1; issue_wr.valid = 1; issue_wr.src = SRC_ALU; issue_wr.dst = 5;
        #1;
        n_vec++; if (issue_tag !== 0) begin n_err++; $display("FAIL basic_tag: got %0d want 0", issue_tag); end
        tick(); idle();
        #1;
        n_vec++; if (count !== 1) begin n_err++; $display("FAIL basic_count1: got %0d want 1", count); end
        n_vec++; if (rs_busy !== 1 || rs_fwd_valid !== 0) begin n_err++; $display("FAIL basic_busy: got %b/%b want 1/0", rs_busy, rs_fwd_valid); end
        alu_valid = 1; alu_tag = 0; alu_value = 32'h1234;
        tick(); idle();
        #1;
        n_vec++; if (rs_fwd_valid !== FWD || rs_busy !== !FWD) begin
            n_err++; $display("FAIL basic_fwd: got fv=%b busy=%b want fv=%b busy=%b", rs_fwd_valid, rs_busy, FWD, !FWD); end
        n_vec++; if (rs_fwd_value !== (FWD ? 32'h1234 : 32'h0)) begin n_err++; $display("FAIL basic_fwd_value: got %h", rs_fwd_value); end
        n_vec++; if (rf_we !== 0) begin n_err++; $display("FAIL basic_early_we: got %b want 0", rf_we); end
        tick();
        n_vec++; if (rf_we !== 1 || rf_waddr !== 5 || rf_wdata !== 32'h1234) begin
            n_err++; $display("FAIL basic_retire: got %b/%0d/%h want 1/5/1234", rf_we, rf_waddr, rf_wdata); end
        n_vec++; if (count !== 0) begin n_err++; $display("FAIL basic_count0: got %0d want 0", count); end
        n_vec++; if (rs_fwd_valid !== FWD || rs_busy !== !FWD) begin
            n_err++; $display("FAIL basic_rf_stage: got fv=%b busy=%b", rs_fwd_valid, rs_busy); end
        tick();
        n_vec++; if (rf_we !== 0) begin n_err++; $display("FAIL basic_we_drop: got %b want 0", rf_we); end
    endtask

    task automatic test_in_order();
        do_reset();
        do_issue(SRC_MEM, 8, 1);
        do_issue(SRC_ALU, 8, 1);
        rt_addr = 8;
        alu_valid = 1; alu_tag = 1; alu_value = 32'hB;
        tick(); idle();
        #1;
        n_vec++; if (rt_fwd_valid !== FWD || rt_fwd_value !== (FWD ? 32'hB : 32'h0) || rt_busy !== !FWD) begin
            n_err++; $display("FAIL order_fwd_young: got %b/%h/%b", rt_fwd_valid, rt_fwd_value, rt_busy); end
        tick();
        n_vec++; if (rf_we !== 0 || count !== 2) begin n_err++; $display("FAIL order_hold: got we=%b count=%0d want 0/2", rf_we, count); end
        mem_valid = 1; mem_tag = 0; mem_value = 32'hA;
        tick(); idle();
        tick();
        n_vec++; if (rf_we !== 1 || rf_waddr !== 8 || rf_wdata !== 32'hA) begin
            n_err++; $display("FAIL order_first: got %b/%0d/%h want 1/8/a", rf_we, rf_waddr, rf_wdata); end
        tick();
        n_vec++; if (rf_we !== 1 || rf_waddr !== 8 || rf_wdata !== 32'hB) begin
            n_err++; $display("FAIL order_second: got %b/%0d/%h want 1/8/b", rf_we, rf_waddr, rf_wdata); end
        n_vec++; if (count !== 0) begin n_err++; $display("FAIL order_count: got %0d want 0", count); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_issue(SRC_ALU, 5'(i + 1), 1);
        #1;
        n_vec++; if (issue_ready !== 0 || count !== DEPTH) begin
            n_err++; $display("FAIL full: got ready=%b count=%0d want 0/%0d", issue_ready, count, DEPTH); end
        alu_valid = 1; alu_tag = 0; alu_value = 32'h11;
        tick(); idle();
        #1;
        n_vec++; if (issue_ready !== 0) begin n_err++; $display("FAIL full_stall: got %b want 0", issue_ready); end
        tick();
        #1;
        n_vec++; if (issue_ready !== 1 || count !== DEPTH - 1 || issue_tag !== 0) begin
            n_err++; $display("FAIL wrap: got ready=%b count=%0d tag=%0d want 1/%0d/0", issue_ready, count, issue_tag, DEPTH - 1); end
        n_vec++; if (rf_we !== 1 || rf_waddr !== 1) begin n_err++; $display("FAIL wrap_retire: got %b/%0d want 1/1", rf_we, rf_waddr); end
        do_issue(SRC_ALU, 9, 1);
        n_vec++; if (count !== DEPTH) begin n_err++; $display("FAIL wrap_count: got %0d want %0d", count, DEPTH); end
    endtask

    task automatic test_src_mismatch();
        do_reset();
        do_issue(SRC_NOP, 3, 1);
        rs_addr = 3;
        alu_valid = 1; alu_tag = 0; alu_value = 32'h55;
        mem_valid = 1; mem_tag = 0; mem_value = 32'h66;
        tick(); idle();
        #1;
        n_vec++; if (rs_busy !== 1 || rs_fwd_valid !== 0) begin n_err++; $display("FAIL mismatch_ignored: got %b/%b want 1/0", rs_busy, rs_fwd_valid); end
        aux_valid = 1; aux_tag = 0; aux_value = 32'h77;
        tick(); idle();
        #1;
        n_vec++; if (rs_fwd_valid !== FWD || rs_fwd_value !== (FWD ? 32'h77 : 32'h0)) begin
            n_err++; $display("FAIL aux_fwd: got %b/%h", rs_fwd_valid, rs_fwd_value); end
        tick();
        n_vec++; if (rf_we !== 1 || rf_waddr !== 3 || rf_wdata !== 32'h77) begin
            n_err++; $display("FAIL aux_retire: got %b/%0d/%h want 1/3/77", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_null_issue();
        do_reset();
        do_issue(SRC_ALU, 0, 1);
        do_issue(SRC_ALU, 7, 0);
        rs_addr = 0; rt_addr = 7;
        #1;
        n_vec++; if (count !== 0 || issue_ready !== 1) begin n_err++; $display("FAIL null_count: got %0d/%b want 0/1", count, issue_ready); end
        n_vec++; if (rs_busy !== 0 || rs_fwd_valid !== 0 || rs_fwd_value !== 0 || rt_busy !== 0 || rt_fwd_valid !== 0) begin
            n_err++; $display("FAIL null_query: got rs %b/%b/%h rt %b/%b", rs_busy, rs_fwd_valid, rs_fwd_value, rt_busy, rt_fwd_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) do_issue(SRC_ALU, 5'(i + 1), 1);
        flush = 1;
        issue_valid = 1; issue_wr.valid = 1; issue_wr.src = SRC_ALU; issue_wr.dst = 4;
        #1;
        n_vec++; if (issue_ready !== 0) begin n_err++; $display("FAIL flush_ready: got %b want 0", issue_ready); end
        tick(); idle();
        #1;
        n_vec++; if (count !== 0 || issue_tag !== 0) begin n_err++; $display("FAIL flush_count: got %0d/%0d want 0/0", count, issue_tag); end
        alu_valid = 1; alu_tag = 1; alu_value = 32'hDEAD;
        tick(); idle();
        rs_addr = 2; rt_addr = 4;
        tick();
        #1;
        n_vec++; if (count !== 0 || rf_we !== 0 || rs_busy !== 0 || rs_fwd_valid !== 0 || rt_busy !== 0) begin
            n_err++; $display("FAIL flush_late: got count=%0d we=%b rs=%b/%b rt=%b", count, rf_we, rs_busy, rs_fwd_valid, rt_busy); end
    endtask

    task automatic test_random();
        bit          eb, ef;
        logic [31:0] ev;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            flush          = ($urandom_range(0, 29) == 0);
            issue_valid    = ($urandom_range(0, 9) < 6);
            issue_wr.valid = ($urandom_range(0, 9) != 0);
            issue_wr.src   = wr_src_t'($urandom_range(0, 2));
            issue_wr.dst   = 5'($urandom_range(0, 7));
            issue_wr.value = $urandom;
            alu_valid = ($urandom_range(0, 9) < 4); alu_tag = TW'($urandom); alu_value = $urandom;
            mem_valid = ($urandom_range(0, 9) < 4); mem_tag = TW'($urandom); mem_value = $urandom;
            aux_valid = ($urandom_range(0, 9) < 4); aux_tag = TW'($urandom); aux_value = $urandom;
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
            #1;
            n_vec++; if (issue_ready !== ((mq.size() < DEPTH) && !flush)) begin
                n_err++; $display("FAIL rnd_ready cyc %0d: got %b size %0d", cyc, issue_ready, mq.size()); end
            n_vec++; if (int'(issue_tag) !== m_tail) begin n_err++; $display("FAIL rnd_tag cyc %0d: got %0d want %0d", cyc, issue_tag, m_tail); end
            n_vec++; if (int'(count) !== mq.size()) begin n_err++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, count, mq.size()); end
            n_vec++; if (rf_we !== m_rf_we) begin n_err++; $display("FAIL rnd_rf_we cyc %0d: got %b want %b", cyc, rf_we, m_rf_we); end
            if (m_rf_we) begin
                n_vec++; if (rf_waddr !== m_rf_waddr || rf_wdata !== m_rf_wdata) begin
                    n_err++; $display("FAIL rnd_rf cyc %0d: got %0d/%h want %0d/%h", cyc, rf_waddr, rf_wdata, m_rf_waddr, m_rf_wdata); end
            end
            model_query(rs_addr, eb, ef, ev);
            n_vec++; if (rs_busy !== eb || rs_fwd_valid !== ef || rs_fwd_value !== ev) begin
                n_err++; $display("FAIL rnd_rs cyc %0d a=%0d: got %b/%b/%h want %b/%b/%h", cyc, rs_addr, rs_busy, rs_fwd_valid, rs_fwd_value, eb, ef, ev); end
            model_query(rt_addr, eb, ef, ev);
            n_vec++; if (rt_busy !== eb || rt_fwd_valid !== ef || rt_fwd_value !== ev) begin
                n_err++; $display("FAIL rnd_rt cyc %0d a=%0d: got %b/%b/%h want %b/%b/%h", cyc, rt_addr, rt_busy, rt_fwd_valid, rt_fwd_value, eb, ef, ev); end
            tick();
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_in_order();
        test_full_wrap();
        test_src_mismatch();
        test_null_issue();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/write_back_scoreboard.md
# write_back_scoreboard

In-order write-back scoreboard that consumes the `write_reg_t` descriptors produced by the decode-side write-register logic. It holds each pending GPR write until its result arrives from the ALU, memory or auxiliary (HI/LO/CP0) path, then retires writes in program order to the register-file write port. It also answers RAW hazard and forwarding queries for the decode stage's two source operands.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries. Must be a power of two, 2..8. `TW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  drop all queued entries.
- `issue_valid`  in  1  descriptor offered.
- `issue_ready`  out  1  `!full && !flush`.
- `issue_wr`  in  `write_reg_t`  descriptor fields used: `valid`, `src` (`SRC_ALU`/`SRC_MEM`/`SRC_NOP`), `dst[4:0]`. `value` is ignored.
- `issue_tag`  out  TW  tag of the entry being allocated; equals the tail pointer.
- `alu_valid`, `alu_tag`, `alu_value`  in  1/TW/32  ALU result.
- `mem_valid`, `mem_tag`, `mem_value`  in  1/TW/32  load result.
- `aux_valid`, `aux_tag`, `aux_value`  in  1/TW/32  HI/LO/CP0 result.
- `rf_we`, `rf_waddr`, `rf_wdata`  out  1/5/32  register-file write, registered.
- `rs_addr`, `rt_addr`  in  5/5  query addresses.
- `rs_busy`, `rs_fwd_valid`, `rs_fwd_value`  out  1/1/32  rs query result; the same set exists for rt.
- `count`  out  TW+1  occupied entries.

## Operation
- Each entry holds `dst`, `src`, `done`, and `value[31:0]`. The queue is circular with head and tail pointers of TW bits each, plus `count`.
- Allocation happens when `issue_valid && issue_ready && issue_wr.valid && issue_wr.dst != 0`. The entry is written at the tail with `done=0`, the tail increments (wrapping modulo DEPTH), and `count` increments.
- If `issue_wr.valid=0` or `dst=0`, the handshake still completes but no entry is allocated.
- Completion: a port completes an entry only if the entry is occupied, `!done`, and its `src` matches the port (alu↔`SRC_ALU`, mem↔`SRC_MEM`, aux↔`SRC_NOP`). On completion, `value` is latched and `done` is set.
  - A mismatched or stale tag is ignored.
  - If two ports hit the same tag in one cycle, the matching port wins. With two matching ports, the priority is ALU > mem > aux.
- Retire: if the head entry has `done=1` at an edge, that edge pops it (head increments, `count` decrements) and loads `rf_we=1`, `rf_waddr=dst`, `rf_wdata=value`. Otherwise `rf_we` is loaded with 0. At most one retire per cycle.
- Issue and retire in the same cycle: `count` is unchanged. `issue_ready` does not account for a same-cycle retire, so a full queue stalls for one cycle.
- Query (combinational, per port, address `a`):
  - `a==0`: all outputs 0.
  - Otherwise scan occupied entries from youngest to oldest. On the first match:
    - `done=1`: `fwd_valid=1`, `fwd_value=value`, `busy=0`.
    - `done=0`: `busy=1`, `fwd_valid=0`.
  - If no entry matches but `rf_we && rf_waddr==a`, then `fwd_valid=1` and `fwd_value=rf_wdata`.
  - `fwd_value` is 0 whenever `fwd_valid=0`.
- Flush resets head, tail and `count` to 0 and clears all `done` bits at the next edge. Flush beats issue and completion in the same cycle. A write already in the `rf_*` register still completes.

## Timing
- Reset values: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `count=0`, head=tail=0, all `done=0`. `issue_ready=1` and query outputs are 0 while in reset.
- Completion at edge E makes the entry forwardable immediately after E.
- If that entry is at the head, it retires at E+1, and `rf_we` is high for the cycle following E+1. Minimum completion-to-write latency is 2 edges.
- Asserting reset mid-operation discards all entries and the pending `rf_*` write immediately (asynchronously).
- `issue_tag` and all query outputs are combinational from the current state and inputs.

## Configuration
- `WB_SCOREBOARD_FORWARD_EN`:
  - Defined: forwarding operates as described above.
  - Undefined: all `*_fwd_valid`/`*_fwd_value` outputs are tied to 0, and `busy=1` on any matching queue entry (done or not) or on an `rf_*` stage match.

## Test plan
- Reset, issue ADDU with `dst=5`/`SRC_ALU` (tag 0), then `alu_valid` with tag 0 and value `0x1234` → `rs_fwd_valid=1` for `rs_addr=5`; `rf_we=1`, `rf_waddr=5`, `rf_wdata=0x1234` two edges after completion; `count` returns to 0.
- Issue LW→r8 (tag 0) then ADDI→r8 (tag 1); complete tag 1 first with `0xB` → `rt_addr=8` forwards `0xB`, nothing retires; complete tag 0 with mem `0xA` → retires in order: r8=`0xA`, then r8=`0xB`.
- Issue DEPTH entries → `issue_ready=0`, `count=DEPTH`; complete and retire the head → `issue_ready` returns to 1; the next allocation's tag wraps to 0.
- Issue MFHI→r3 (`SRC_NOP`); an `alu_valid` pulse on its tag is ignored (`busy` stays 1); an `aux_valid` pulse with `0x77` then completes it.
- Issue `dst=0` and `valid=0` descriptors → handshake completes, `count` stays 0; query with addr 0 → all outputs 0.
- With 3 entries pending, assert `flush` together with `issue_valid` → `count=0` next cycle and the issue is dropped; a late completion on an old tag is ignored.
